// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped branch target buffer with 2-bit direction counters
//
// Purpose: looks up the fetch PC each cycle and supplies the predicted next
// fetch PC; trains from resolved branch outcomes reported by EX; flags
// mispredictions with a flush and the corrected redirect PC; keeps hit and
// misprediction statistics.
//
// Ports:
//   clock, reset          - clock; asynchronous active-high reset
//   fetch_pc              - PC being fetched this cycle
//   pred_taken            - lookup hit with counter in a taken state
//   pred_target           - predicted next fetch PC
//   upd_valid             - a resolved control-flow instruction is presented
//   upd_pc, upd_taken     - its PC and actual direction
//   upd_target            - its actual taken target
//   upd_pred_taken/target - the prediction that was made for it at fetch
//   flush, redirect_pc    - misprediction squash and corrected next PC
//   hit_count             - number of cycles whose lookup hit
//   mispredict_count      - number of cycles with flush asserted
module btb_predictor #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int STAT_W  = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [PC_W-1:0]   upd_pred_target,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int TAG_W = PC_W - IDX_W - 2;

  // Table kept as packed vectors so the whole table clears in one reset assignment.
  logic [ENTRIES-1:0]             valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
  logic [ENTRIES-1:0][PC_W-1:0]   target_q;
  logic [ENTRIES-1:0][1:0]        ctr_q;
  logic [STAT_W-1:0]              hit_count_q, hit_count_d;
  logic [STAT_W-1:0]              mis_count_q, mis_count_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             lk_hit, u_hit;

  logic             wr_en;
  logic [PC_W-1:0]  wr_target_d;
  logic [1:0]       wr_ctr_d;

  // Lookup reads only registered state, so a same-cycle update is not visible yet.
  assign f_idx       = fetch_pc[IDX_W+1:2];
  assign f_tag       = fetch_pc[PC_W-1:IDX_W+2];
  assign lk_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = lk_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? target_q[f_idx] : fetch_pc + PC_W'(4);

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[PC_W-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // A wrong direction, or a taken branch that went somewhere other than predicted.
  assign flush = upd_valid &&
                 ((upd_taken != upd_pred_taken) ||
                  (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = !flush   ? '0 :
                       upd_taken ? upd_target : upd_pc + PC_W'(4);

  always_comb begin
    wr_en       = 1'b0;
    wr_target_d = target_q[u_idx];
    wr_ctr_d    = ctr_q[u_idx];
    if (upd_valid) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_target_d = upd_target;
          if (ctr_q[u_idx] != 2'd3) wr_ctr_d = ctr_q[u_idx] + 2'd1;
        end else if (ctr_q[u_idx] != 2'd0) begin
          wr_ctr_d = ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate weakly taken; a not-taken miss leaves the table alone.
        wr_en       = 1'b1;
        wr_target_d = upd_target;
        wr_ctr_d    = 2'd2;
      end
    end
  end

  assign hit_count_d = lk_hit ? hit_count_q + STAT_W'(1) : hit_count_q;
  assign mis_count_d = flush  ? mis_count_q + STAT_W'(1) : mis_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      tag_q       <= '0;
      target_q    <= '0;
      ctr_q       <= {ENTRIES{2'd1}};
      hit_count_q <= '0;
      mis_count_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= wr_target_d;
        ctr_q[u_idx]    <= wr_ctr_d;
      end
      hit_count_q <= hit_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign hit_count        = hit_count_q;
  assign mispredict_count = mis_count_q;

endmodule
